// File: rtl/cic_pkg.sv
// cic_pkg
// Shared types and defaults for the CIC decimation sequencer.
//   state_e        : sequencer FSM states
//   N_DEF / RW_DEF : default comb-stage count and rate/phase width
//   R_DEF_DEF      : default rate loaded at reset
//   sanitise_rate  : maps a requested rate of 0 to 1 (a rate of 0 has no meaning)
package cic_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    localparam int N_DEF     = 3;
    localparam int RW_DEF    = 16;
    localparam int R_DEF_DEF = 5;

    // Operates on a 32-bit container so it serves any RW up to 32.
    function automatic logic [31:0] sanitise_rate(input logic [31:0] rate);
        return (rate == 32'd0) ? 32'd1 : rate;
    endfunction

endpackage

// File: rtl/cic_stage_sequencer.sv
// cic_stage_sequencer
// N-deep one-hot shift register that walks the comb-stage enables.
//   i_clk       : clock
//   i_rst_n     : asynchronous active-low reset
//   i_start     : one-cycle pulse; stage 0 is enabled on the following cycle
//   o_stage_en  : one-hot stage enable, bit k = comb stage k
//   o_done      : high while the last stage is enabled
module cic_stage_sequencer #(
    parameter int N = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    output logic [N-1:0] o_stage_en,
    output logic         o_done
);

    logic [N-1:0] shift_q;
    logic [N-1:0] shift_d;

    always_comb begin
        shift_d    = shift_q << 1;
        shift_d[0] = i_start;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign o_stage_en = shift_q;
    assign o_done     = shift_q[N-1];

endmodule

// File: rtl/cic_decim_ctrl.sv
// cic_decim_ctrl
// Sequencer for the CIC decimation path: counts input strobes against a
// programmable rate, fires the decimation strobe on each wrap, walks the comb
// stage enables, then holds the result on a valid/ready handshake.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_enable                : run request (low -> flush then idle)
//   i_cfg_valid/i_cfg_rate  : rate offer, accepted only while o_cfg_ready
//   o_cfg_ready             : high in IDLE
//   i_ready                 : input sample strobe
//   o_int_en                : integrator enable (i_ready while running)
//   o_dec_strobe            : one-cycle decimation strobe
//   o_comb_en               : one-hot comb-stage enable
//   o_valid / i_out_ready   : output handshake
//   o_overrun/i_overrun_clr : sticky dropped-event flag and its clear
//   o_phase                 : current phase count
//   o_busy                  : comb sequence or output handshake in flight
//
// state   | meaning
// S_IDLE  | stopped, phase 0, rate may be reconfigured
// S_RUN   | counting strobes, issuing decimation events
// S_FLUSH | no new events; waiting for in-flight sequence/handshake
module cic_decim_ctrl
    import cic_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int RW    = RW_DEF,
    parameter int R_DEF = R_DEF_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_enable,
    input  logic          i_cfg_valid,
    input  logic [RW-1:0] i_cfg_rate,
    output logic          o_cfg_ready,
    input  logic          i_ready,
    output logic          o_int_en,
    output logic          o_dec_strobe,
    output logic [N-1:0]  o_comb_en,
    output logic          o_valid,
    input  logic          i_out_ready,
    output logic          o_overrun,
    input  logic          i_overrun_clr,
    output logic [RW-1:0] o_phase,
    output logic          o_busy
);

    state_e        state_q;
    logic [RW-1:0] rate_q;
    logic [RW-1:0] rate_m1_q;
    logic [RW-1:0] phase_q;
    logic [RW-1:0] phase_d;
    logic          strobe_q;
    logic          valid_q;
    logic          valid_d;
    logic          overrun_q;
    logic          overrun_d;

    logic          seq_done;
    logic [N-1:0]  comb_en;
    logic          busy;
    logic          running;
    logic          hit;
    logic          event_ok;
    logic          event_drop;
    logic          cfg_acc;
    logic [RW-1:0] rate_san;
    logic [RW-1:0] rate_new;

    cic_stage_sequencer #(
        .N (N)
    ) u_seq (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (strobe_q),
        .o_stage_en (comb_en),
        .o_done     (seq_done)
    );

    // Strobe, stage walk and held valid are back-to-back, so their OR covers
    // the whole interval from the strobe until the output is taken.
    assign busy       = strobe_q | (|comb_en) | valid_q;
    assign running    = (state_q == S_RUN);
    assign hit        = running & i_ready & (phase_q == rate_m1_q);
    assign event_ok   = hit & ~busy;
    assign event_drop = hit & busy;
    assign cfg_acc    = i_cfg_valid & (state_q == S_IDLE);
    assign rate_san   = RW'(sanitise_rate(32'(i_cfg_rate)));
    // A rate offered in the same cycle as the start request is the one used.
    assign rate_new   = cfg_acc ? rate_san : rate_q;

    always_comb begin
        phase_d = phase_q;
        if (running && i_ready) begin
            phase_d = hit ? '0 : phase_q + 1'b1;
        end else if (state_q == S_FLUSH && !busy) begin
            phase_d = '0;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (seq_done) begin
            valid_d = 1'b1;
        end else if (valid_q && i_out_ready) begin
            valid_d = 1'b0;
        end
    end

    // A new drop takes priority over a clear in the same cycle.
    always_comb begin
        overrun_d = overrun_q;
        if (event_drop) begin
            overrun_d = 1'b1;
        end else if (i_overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            rate_q    <= RW'(R_DEF);
            rate_m1_q <= RW'(R_DEF - 1);
            phase_q   <= '0;
            strobe_q  <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            strobe_q  <= event_ok;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            case (state_q)
                S_IDLE: begin
                    if (cfg_acc) begin
                        rate_q <= rate_san;
                    end
                    if (i_enable) begin
                        state_q   <= S_RUN;
                        rate_m1_q <= rate_new - 1'b1;
                    end
                end
                S_RUN: begin
                    if (!i_enable) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (!busy) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cfg_ready  = (state_q == S_IDLE);
    assign o_int_en     = i_ready & running;
    assign o_dec_strobe = strobe_q;
    assign o_comb_en    = comb_en;
    assign o_valid      = valid_q;
    assign o_overrun    = overrun_q;
    assign o_phase      = phase_q;
    assign o_busy       = busy;

endmodule
